// File: rtl/sift_pkg.sv
// Shared types and constants for the DoG keypoint scanner.
package sift_pkg;

    // Signed DoG sample width
    localparam int unsigned DOG_W       = 9;
    localparam int unsigned NUM_OFFSETS = 9;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DECIDE,
        WRITE,
        NEXT,
        FINISH
    } state_e;

    // Neighbour offsets as 2-bit signed values, entry k at bits [2k+1:2k].
    // Entry 0 is the centre so the centre sample returns first.
    localparam logic [NUM_OFFSETS-1:0][1:0] OFFSET_DX = {
        2'b01, 2'b00, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00
    };
    localparam logic [NUM_OFFSETS-1:0][1:0] OFFSET_DY = {
        2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00
    };

    // Pack {y,x} with x in the low coord_w bits; caller truncates to its width
    function automatic logic [31:0] pack_yx(input logic [15:0] y, input logic [15:0] x,
                                            input int unsigned coord_w);
        return (32'(y) << coord_w) | 32'(x);
    endfunction

endpackage

// File: rtl/extremum_compare.sv
// Accumulates strict local-max / local-min flags for one centre pixel.
module extremum_compare
    import sift_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    valid_i,
    input  logic [3:0]              tag_i,
    input  logic signed [DOG_W-1:0] above_i,
    input  logic signed [DOG_W-1:0] mid_i,
    input  logic signed [DOG_W-1:0] below_i,
    output logic signed [DOG_W-1:0] centre_o,
    output logic                    is_max_o,
    output logic                    is_min_o
);

    logic signed [DOG_W-1:0] centre_q, centre_d;
    logic                    is_max_q, is_max_d;
    logic                    is_min_q, is_min_d;

    // Next-state: tag 0 latches the centre, later tags compare all three layers
    always_comb begin
        centre_d = centre_q;
        is_max_d = is_max_q;
        is_min_d = is_min_q;
        if (clear_i) begin
            centre_d = '0;
            is_max_d = 1'b1;
            is_min_d = 1'b1;
        end else if (valid_i) begin
            if (tag_i == 4'd0) begin
                // The centre's own mid sample is not a neighbour
                centre_d = mid_i;
                is_max_d = (mid_i > above_i) && (mid_i > below_i);
                is_min_d = (mid_i < above_i) && (mid_i < below_i);
            end else begin
                is_max_d = is_max_q && (centre_q > above_i) && (centre_q > mid_i) &&
                           (centre_q > below_i);
                is_min_d = is_min_q && (centre_q < above_i) && (centre_q < mid_i) &&
                           (centre_q < below_i);
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            centre_q <= '0;
            is_max_q <= 1'b1;
            is_min_q <= 1'b1;
        end else begin
            centre_q <= centre_d;
            is_max_q <= is_max_d;
            is_min_q <= is_min_d;
        end
    end

    assign centre_o = centre_q;
    assign is_max_o = is_max_q;
    assign is_min_o = is_min_q;

endmodule

// File: rtl/dog_keypoint_detect.sv
// Scans interior pixels of the middle DoG layer and records 26-neighbour extrema.
module dog_keypoint_detect
    import sift_pkg::*;
#(
    parameter int unsigned DIMENSION       = 64,
    parameter int unsigned READ_LATENCY    = 2,
    parameter int unsigned CONTRAST_THRESH = 8,
    parameter int unsigned MAX_KEYPOINTS   = 256
) (
    input  logic                                    clk,
    input  logic                                    rst_in_n,
    input  logic                                    start,
    input  logic signed [DOG_W-1:0]                 above_pix,
    input  logic signed [DOG_W-1:0]                 mid_pix,
    input  logic signed [DOG_W-1:0]                 below_pix,
    output logic [$clog2(DIMENSION*DIMENSION)-1:0]  address,
    output logic                                    busy,
    output logic                                    done,
    output logic [$clog2(MAX_KEYPOINTS)-1:0]        kp_addr,
    output logic [2*$clog2(DIMENSION)-1:0]          kp_data,
    output logic                                    kp_wea,
    output logic [$clog2(MAX_KEYPOINTS):0]          kp_count,
    output logic                                    overflow
);

    localparam int unsigned ADDR_W    = $clog2(DIMENSION * DIMENSION);
    localparam int unsigned COORD_W   = $clog2(DIMENSION);
    localparam int unsigned KP_ADDR_W = $clog2(MAX_KEYPOINTS);
    localparam int unsigned KP_CNT_W  = KP_ADDR_W + 1;
    localparam int unsigned KP_DATA_W = 2 * COORD_W;
    localparam int unsigned MAG_W     = DOG_W + 1;

    state_e                 state_q, state_d;
    logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   kp_wea_q, kp_wea_d;
    logic [KP_ADDR_W-1:0]   kp_addr_q, kp_addr_d;
    logic [KP_DATA_W-1:0]   kp_data_q, kp_data_d;
    logic [KP_CNT_W-1:0]    kp_count_q, kp_count_d;
    logic                   overflow_q, overflow_d;
    logic                   scan_clear;

    // Tag pipeline aligned with BRAM latency; stage 0 follows the issued address
    logic [READ_LATENCY-1:0]      vld_q, vld_d;
    logic [READ_LATENCY-1:0][3:0] tag_q, tag_d;

    logic signed [DOG_W-1:0] centre;
    logic                    is_max, is_min;
    logic signed [MAG_W-1:0] centre_ext;
    logic [MAG_W-1:0]        centre_mag;
    logic                    kp_found;

    // Linear address of neighbour k around (x,y); centres are interior so no underflow
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input logic [3:0] k);
        int ax;
        int ay;
        ax = int'(x) + int'($signed(OFFSET_DX[k]));
        ay = int'(y) + int'($signed(OFFSET_DY[k]));
        return ADDR_W'(ay * int'(DIMENSION) + ax);
    endfunction

    extremum_compare u_extremum_compare (
        .clk_i    (clk),
        .rst_ni   (rst_in_n),
        .clear_i  (scan_clear),
        .valid_i  (vld_q[READ_LATENCY-1]),
        .tag_i    (tag_q[READ_LATENCY-1]),
        .above_i  (above_pix),
        .mid_i    (mid_pix),
        .below_i  (below_pix),
        .centre_o (centre),
        .is_max_o (is_max),
        .is_min_o (is_min)
    );

    // Magnitude is one bit wider so -256 maps to +256
    assign centre_ext = {centre[DOG_W-1], centre};
    assign centre_mag = centre[DOG_W-1] ? MAG_W'(-centre_ext) : MAG_W'(centre_ext);
    assign kp_found   = (is_max || is_min) && (centre_mag >= MAG_W'(CONTRAST_THRESH));

    // Issue tag shift register
    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        vld_d[0] = (state_q == ISSUE);
        tag_d[0] = cnt_q;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end
    end

    // Scan FSM next-state; address is precomputed one step ahead so it is registered
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        address_d  = address_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        kp_wea_d   = 1'b0;
        kp_addr_d  = kp_addr_q;
        kp_data_d  = kp_data_q;
        kp_count_d = kp_count_q;
        overflow_d = overflow_q;
        scan_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    kp_count_d = '0;
                    overflow_d = 1'b0;
                    x_d        = COORD_W'(1);
                    y_d        = COORD_W'(1);
                    busy_d     = 1'b1;
                    cnt_d      = 4'd0;
                    address_d  = pix_addr(COORD_W'(1), COORD_W'(1), 4'd0);
                    scan_clear = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == 4'(NUM_OFFSETS - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = DRAIN;
                end else begin
                    cnt_d     = cnt_q + 4'd1;
                    address_d = pix_addr(x_q, y_q, cnt_q + 4'd1);
                end
            end
            DRAIN: begin
                if (cnt_q == 4'(READ_LATENCY - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DECIDE: begin
                if (kp_found) begin
                    state_d = WRITE;
                    if (kp_count_q < KP_CNT_W'(MAX_KEYPOINTS)) begin
                        kp_wea_d  = 1'b1;
                        kp_addr_d = kp_count_q[KP_ADDR_W-1:0];
                        kp_data_d = KP_DATA_W'(pack_yx(16'(y_q), 16'(x_q), COORD_W));
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    state_d = NEXT;
                end
            end
            WRITE: begin
                if (kp_wea_q) begin
                    kp_count_d = kp_count_q + 1'b1;
                end
                state_d = NEXT;
            end
            NEXT: begin
                if (x_q == COORD_W'(DIMENSION - 2)) begin
                    x_d = COORD_W'(1);
                    if (y_q == COORD_W'(DIMENSION - 2)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FINISH;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
                if (state_d != FINISH) begin
                    address_d  = pix_addr(x_d, y_d, 4'd0);
                    scan_clear = 1'b1;
                    state_d    = ISSUE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            address_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            kp_wea_q   <= 1'b0;
            kp_addr_q  <= '0;
            kp_data_q  <= '0;
            kp_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            address_q  <= address_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            kp_wea_q   <= kp_wea_d;
            kp_addr_q  <= kp_addr_d;
            kp_data_q  <= kp_data_d;
            kp_count_q <= kp_count_d;
            overflow_q <= overflow_d;
        end
    end

    // Read-tag pipeline registers
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
        end
    end

    assign address  = address_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign kp_wea   = kp_wea_q;
    assign kp_addr  = kp_addr_q;
    assign kp_data  = kp_data_q;
    assign kp_count = kp_count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_dog_keypoint_detect.sv
// Directed bench for dog_keypoint_detect on a 16x16 image with a 2-entry keypoint BRAM.
module tb_dog_keypoint_detect;

    localparam int D    = 16;
    localparam int RL   = 2;
    localparam int TH   = 8;
    localparam int MAXK = 2;
    // 14*14 interior pixels at 9+2+1+1 cycles each
    localparam int BASE_CYCLES = (D - 2) * (D - 2) * 13;

    logic              clk;
    logic              rst_in_n;
    logic              start;
    logic signed [8:0] above_pix, mid_pix, below_pix;
    logic [7:0]        address;
    logic              busy, done;
    logic [0:0]        kp_addr;
    logic [7:0]        kp_data;
    logic              kp_wea;
    logic [1:0]        kp_count;
    logic              overflow;

    logic signed [8:0] mem_a [D*D];
    logic signed [8:0] mem_m [D*D];
    logic signed [8:0] mem_b [D*D];
    logic signed [8:0] a_s1, m_s1, b_s1;

    logic [0:0] wr_addr [16];
    logic [7:0] wr_data [16];
    int         wr_n = 0;

    int errors = 0;
    int checks = 0;

    dog_keypoint_detect #(
        .DIMENSION       (D),
        .READ_LATENCY    (RL),
        .CONTRAST_THRESH (TH),
        .MAX_KEYPOINTS   (MAXK)
    ) dut (
        .clk       (clk),
        .rst_in_n  (rst_in_n),
        .start     (start),
        .above_pix (above_pix),
        .mid_pix   (mid_pix),
        .below_pix (below_pix),
        .address   (address),
        .busy      (busy),
        .done      (done),
        .kp_addr   (kp_addr),
        .kp_data   (kp_data),
        .kp_wea    (kp_wea),
        .kp_count  (kp_count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-cycle BRAM read model
    always @(posedge clk) begin
        a_s1      <= mem_a[address];
        m_s1      <= mem_m[address];
        b_s1      <= mem_b[address];
        above_pix <= a_s1;
        mid_pix   <= m_s1;
        below_pix <= b_s1;
    end

    // Keypoint write log
    always @(negedge clk) begin
        if (kp_wea && wr_n < 16) begin
            wr_addr[wr_n] <= kp_addr;
            wr_data[wr_n] <= kp_data;
            wr_n          <= wr_n + 1;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < D * D; i++) begin
            mem_a[i] = '0;
            mem_m[i] = '0;
            mem_b[i] = '0;
        end
    endtask

    task automatic run_scan(input bit extra_start, output int cycles, output logic [7:0] first_addr,
                            output logic busy_seen, output bit timed_out);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_addr = address;
        busy_seen  = busy;
        cycles     = 0;
        timed_out  = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            start = (extra_start && i == 100);
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        start    = 1'b0;
        rst_in_n = 1'b1;
        #2 rst_in_n = 1'b0;
        #1;
        checks++; if (address !== 8'd0) begin errors++; $display("FAIL reset_address: got %0h want 0", address); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (kp_wea !== 1'b0) begin errors++; $display("FAIL reset_kp_wea: got %b want 0", kp_wea); end
        checks++; if ({kp_addr, kp_data, kp_count} !== 11'd0) begin
            errors++; $display("FAIL reset_kp_regs: got %0h/%0h/%0h want 0", kp_addr, kp_data, kp_count);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(negedge clk);
        rst_in_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int cyc; logic [7:0] fa; logic bs; bit to; int base;
        clear_mem();
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: done never seen"); end
        checks++; if (cyc !== BASE_CYCLES) begin errors++; $display("FAIL zero_latency: got %0d want %0d", cyc, BASE_CYCLES); end
        checks++; if (fa !== 8'd17) begin errors++; $display("FAIL zero_first_addr: got %0d want 17", fa); end
        checks++; if (bs !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b want 1", bs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", done); end
        checks++; if (wr_n - base !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_n - base); end
        checks++; if (kp_count !== 2'd0) begin errors++; $display("FAIL zero_kp_count: got %0d want 0", kp_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single_max();
        int cyc; logic [7:0] fa; logic bs; bit to; int base;
        clear_mem();
        mem_m[12*D+10] = 9'sd50;
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (to || cyc !== BASE_CYCLES + 1) begin errors++; $display("FAIL max_latency: got %0d want %0d", cyc, BASE_CYCLES + 1); end
        checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL max_writes: got %0d want 1", wr_n - base); end
        else begin
            checks++; if (wr_addr[base] !== 1'b0) begin errors++; $display("FAIL max_addr: got %0d want 0", wr_addr[base]); end
            checks++; if (wr_data[base] !== 8'hCA) begin errors++; $display("FAIL max_data: got %0h want ca", wr_data[base]); end
        end
        checks++; if (kp_count !== 2'd1) begin errors++; $display("FAIL max_kp_count: got %0d want 1", kp_count); end
    endtask

    task automatic test_min_and_ties();
        int cyc; logic [7:0] fa; logic bs; bit to; int base;
        clear_mem();
        mem_m[5*D+13] = -9'sd40;
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL min_writes: got %0d want 1", wr_n - base); end
        else begin
            checks++; if (wr_data[base] !== 8'h5D) begin errors++; $display("FAIL min_data: got %0h want 5d", wr_data[base]); end
        end
        mem_a[5*D+13] = -9'sd40;
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (wr_n - base !== 0) begin errors++; $display("FAIL tie_above_writes: got %0d want 0", wr_n - base); end
        checks++; if (kp_count !== 2'd0) begin errors++; $display("FAIL tie_kp_count: got %0d want 0", kp_count); end
        mem_a[5*D+13] = '0;
        mem_b[5*D+13] = -9'sd40;
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (wr_n - base !== 0) begin errors++; $display("FAIL tie_below_writes: got %0d want 0", wr_n - base); end
    endtask

    task automatic test_threshold_border();
        int cyc; logic [7:0] fa; logic bs; bit to; int base;
        clear_mem();
        mem_m[7*D+7]  = 9'sd5;    // below threshold
        mem_m[9*D+0]  = 9'sd100;  // border column, never a centre
        mem_m[3*D+3]  = 9'sd8;    // exactly at threshold
        mem_m[11*D+9] = -9'sd7;   // one below threshold
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL thresh_writes: got %0d want 1", wr_n - base); end
        else begin
            checks++; if (wr_data[base] !== 8'h33) begin errors++; $display("FAIL thresh_data: got %0h want 33", wr_data[base]); end
        end
    endtask

    task automatic test_neighbours();
        int cyc; logic [7:0] fa; logic bs; bit to; int base;
        clear_mem();
        mem_m[10*D+10] = 9'sd50;   // blocked by a larger below-layer neighbour
        mem_b[11*D+11] = 9'sd60;
        mem_m[10*D+4]  = 9'sd30;   // survives a smaller above-layer neighbour
        mem_a[9*D+3]   = 9'sd29;
        mem_m[3*D+12]  = -9'sd20;  // two equal diagonal mid-layer minima cancel
        mem_m[4*D+13]  = -9'sd20;
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL neigh_writes: got %0d want 1", wr_n - base); end
        else begin
            checks++; if (wr_data[base] !== 8'hA4) begin errors++; $display("FAIL neigh_data: got %0h want a4", wr_data[base]); end
        end
    endtask

    task automatic test_overflow_back_to_back();
        int cyc; logic [7:0] fa; logic bs; bit to; int base;
        clear_mem();
        mem_m[5*D+5]   = 9'sd50;
        mem_m[5*D+10]  = 9'sd50;
        mem_m[12*D+12] = 9'sd50;
        base = wr_n;
        // A second start mid-scan must not restart it
        run_scan(1'b1, cyc, fa, bs, to);
        checks++; if (to || cyc !== BASE_CYCLES + 3) begin errors++; $display("FAIL ovf_latency: got %0d want %0d", cyc, BASE_CYCLES + 3); end
        checks++; if (wr_n - base !== 2) begin errors++; $display("FAIL ovf_writes: got %0d want 2", wr_n - base); end
        else begin
            checks++; if ({wr_addr[base], wr_addr[base+1]} !== 2'b01) begin
                errors++; $display("FAIL ovf_addrs: got %0d,%0d want 0,1", wr_addr[base], wr_addr[base+1]);
            end
            checks++; if ({wr_data[base], wr_data[base+1]} !== 16'h555A) begin
                errors++; $display("FAIL ovf_data: got %0h,%0h want 55,5a", wr_data[base], wr_data[base+1]);
            end
        end
        checks++; if (kp_count !== 2'd2) begin errors++; $display("FAIL ovf_kp_count: got %0d want 2", kp_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    endtask

    task automatic test_reset_midscan();
        int cyc; logic [7:0] fa; logic bs; bit to; int base;
        clear_mem();
        mem_m[1*D+1] = -9'sd256;  // most negative sample, magnitude 256
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1000) @(negedge clk);
        checks++; if (kp_count !== 2'd1) begin errors++; $display("FAIL mid_pre_count: got %0d want 1", kp_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b want 1", busy); end
        #2 rst_in_n = 1'b0;
        #1;
        checks++; if ({address, busy, done, kp_wea} !== 11'd0) begin
            errors++; $display("FAIL mid_reset_ctrl: got addr=%0d busy=%b done=%b wea=%b want 0", address, busy, done, kp_wea);
        end
        checks++; if ({kp_addr, kp_data, kp_count, overflow} !== 12'd0) begin
            errors++; $display("FAIL mid_reset_kp: got %0h/%0h/%0h/%b want 0", kp_addr, kp_data, kp_count, overflow);
        end
        @(negedge clk);
        rst_in_n = 1'b1;
        base = wr_n;
        run_scan(1'b0, cyc, fa, bs, to);
        checks++; if (fa !== 8'd17) begin errors++; $display("FAIL rescan_first_addr: got %0d want 17", fa); end
        checks++; if (to || cyc !== BASE_CYCLES + 1) begin errors++; $display("FAIL rescan_latency: got %0d want %0d", cyc, BASE_CYCLES + 1); end
        checks++; if (wr_n - base !== 1) begin errors++; $display("FAIL rescan_writes: got %0d want 1", wr_n - base); end
        else begin
            checks++; if ({wr_addr[base], wr_data[base]} !== 9'h011) begin
                errors++; $display("FAIL rescan_write: got addr=%0d data=%0h want 0/11", wr_addr[base], wr_data[base]);
            end
        end
        checks++; if (kp_count !== 2'd1) begin errors++; $display("FAIL rescan_kp_count: got %0d want 1", kp_count); end
    endtask

    initial begin
        start    = 1'b0;
        rst_in_n = 1'b1;
        clear_mem();
        test_reset();
        test_all_zero();
        test_single_max();
        test_min_and_ties();
        test_threshold_border();
        test_neighbours();
        test_overflow_back_to_back();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
